// File: rtl/mc_pkg.sv
// ----------------------------------------------------------------------------
// mc_pkg
// Shared types and encodings for the multicycle processor control unit.
//   state_t        : control FSM states
//   OP_*           : instruction opcodes (instr[31:26])
//   ALU_OP_*       : alu_op encodings seen by the ALU control
//   PC_SRC_*       : pc_src mux encodings
//   SRC_B_*        : alu_src_b mux encodings
// The andi/ori opcodes are only decoded when ZERO_EXTEND_EN is defined
// (see mc_decode); their encodings live here unconditionally.
// ----------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [3:0] {
        RST_S,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        ALUWB,
        BRANCH,
        IEXEC,
        IWB,
        JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_LOGIC = 2'b11;

    localparam logic [1:0] PC_SRC_INC    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_BRANCH = 2'b11;

    // States that wait on mem_ready and are therefore subject to the timeout.
    function automatic logic is_mem_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// ----------------------------------------------------------------------------
// mc_decode
// Purely combinational opcode decoder for the control FSM.
// Ports:
//   opcode      in  [5:0] instr[31:26]
//   decode_next out state_t  state to enter after DECODE (FETCH if illegal)
//   illegal     out 1        opcode is not supported
//   is_load     out 1        opcode is lw (selects MEMRD vs MEMWR)
//   zext        out 1        immediate-form logic op needing zero extension
// Macro ZERO_EXTEND_EN: when defined, andi/ori decode to IEXEC with zext=1;
// otherwise they fall into the illegal path and zext is constant 0.
// ----------------------------------------------------------------------------
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    output state_t     decode_next,
    output logic       illegal,
    output logic       is_load,
    output logic       zext
);

    always_comb begin
        decode_next = FETCH;
        illegal     = 1'b0;
        zext        = 1'b0;
        case (opcode)
            OP_RTYPE:       decode_next = EXEC;
            OP_LW, OP_SW:   decode_next = MEMADR;
            OP_BEQ:         decode_next = BRANCH;
            OP_ADDI:        decode_next = IEXEC;
            OP_J:           decode_next = JUMP;
`ifdef ZERO_EXTEND_EN
            OP_ANDI, OP_ORI: begin
                decode_next = IEXEC;
                zext        = 1'b1;
            end
`endif
            default:        illegal = 1'b1;
        endcase
    end

    assign is_load = (opcode == OP_LW);

endmodule

// File: rtl/mc_control.sv
// ----------------------------------------------------------------------------
// mc_control
// Control FSM of a multicycle MIPS-style datapath with a memory-wait timeout.
// Parameter:
//   MEM_TIMEOUT  wait cycles allowed in FETCH/MEMRD/MEMWR before abort
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   opcode [5:0]               instr[31:26] from the instruction register
//   zero                       ALU zero flag (beq)
//   mem_ready                  memory access completes this cycle
//   pc_write, ir_write, mem_write, reg_write          write enables
//   iord, reg_dst, mem_to_reg, alu_src_a              1-bit selects
//   alu_src_b [1:0], alu_op [1:0], pc_src [1:0]      2-bit selects
//   ext_op                     immediate extension: 0 sign, 1 zero
//   illegal_op, mem_err        one-cycle error pulses
// Macro ZERO_EXTEND_EN (handled in mc_decode) enables andi/ori.
// ----------------------------------------------------------------------------
module mc_control
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       ext_op,
    output logic       illegal_op,
    output logic       mem_err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            mem_timeout;

    state_t          dec_next;
    logic            dec_illegal;
    logic            dec_is_load;
    logic            dec_zext;

    mc_decode u_decode (
        .opcode      (opcode),
        .decode_next (dec_next),
        .illegal     (dec_illegal),
        .is_load     (dec_is_load),
        .zext        (dec_zext)
    );

    // The counter only advances while a wait state is stalled; any state
    // change (including the timeout return to FETCH) lets it fall to zero.
    always_comb begin
        mem_timeout = 1'b0;
        wait_cnt_d  = '0;
        if (is_mem_wait_state(state_q) && !mem_ready) begin
            if (wait_cnt_q == LAST_WAIT) begin
                mem_timeout = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
        end
    end

    // Next state and Moore/Mealy outputs; everything defaults to 0 so each
    // state lists only what it asserts.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        alu_op     = ALU_OP_ADD;
        pc_src     = PC_SRC_INC;
        ext_op     = 1'b0;
        illegal_op = 1'b0;
        mem_err    = mem_timeout;

        case (state_q)
            RST_S: state_d = FETCH;

            FETCH: begin
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    pc_src    = PC_SRC_INC;
                    state_d   = DECODE;
                end else if (mem_timeout) begin
                    state_d = FETCH;
                end
            end

            DECODE: begin
                alu_src_b  = SRC_B_BRANCH;
                illegal_op = dec_illegal;
                state_d    = dec_next;
            end

            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_d   = dec_is_load ? MEMRD : MEMWR;
            end

            MEMRD: begin
                iord = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end else if (mem_timeout) begin
                    state_d = FETCH;
                end
            end

            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end

            MEMWR: begin
                iord = 1'b1;
                if (mem_ready) begin
                    mem_write = 1'b1;
                    state_d   = FETCH;
                end else if (mem_timeout) begin
                    state_d = FETCH;
                end
            end

            EXEC: begin
                alu_op  = ALU_OP_FUNCT;
                state_d = ALUWB;
            end

            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end

            BRANCH: begin
                alu_op   = ALU_OP_SUB;
                pc_src   = PC_SRC_BRANCH;
                pc_write = zero;
                state_d  = FETCH;
            end

            // The zero-extended logic ops share the addi path; dec_zext is
            // constant 0 unless ZERO_EXTEND_EN is defined.
            IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                alu_op    = dec_zext ? ALU_OP_LOGIC : ALU_OP_ADD;
                ext_op    = dec_zext;
                state_d   = IWB;
            end

            IWB: begin
                reg_write = 1'b1;
                ext_op    = dec_zext;
                state_d   = FETCH;
            end

            JUMP: begin
                pc_src   = PC_SRC_JUMP;
                pc_write = 1'b1;
                state_d  = FETCH;
            end

            default: state_d = RST_S;
        endcase
    end

    // State and wait counter; reset overrides any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RST_S;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule
